main_ram_sync: RTL

- Next-generation main memory model for the eclair sim: clocked, parametrised in width, depth, lane count and wait states.
- Handshaked (_cs/_ack) instead of edge-triggered on _w, with per-lane write masking and out-of-range detection.
- Sits between the CPU memory interface and backing storage in the simulation top level.
- Drives data only on a registered output, no tristates.

---
 rtl/main_ram_pkg.sv | 18 +
 rtl/main_ram_sync_if.sv | 40 ++++
 rtl/main_ram_array.sv | 68 ++++++
 rtl/main_ram_sync.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/main_ram_pkg.sv
// Shared types and constants for the clocked main memory model (main_ram_sync).
// Optional parity support elsewhere is enabled with MAIN_RAM_SYNC_PARITY_EN.
package main_ram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    function automatic int lane_w(input int width, input int lanes);
        return width / lanes;
    endfunction

endpackage

// File: rtl/main_ram_sync_if.sv
// CPU-side bus of the main memory model; parity signals exist only when
// MAIN_RAM_SYNC_PARITY_EN is defined.
interface main_ram_sync_if #(
    parameter int WIDTH  = 16,
    parameter int LANES  = 2,
    parameter int ADDR_W = 20
);
    logic              _cs;
    logic              _w;
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  wmask;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              _ack;
    logic              addr_err;
`ifdef MAIN_RAM_SYNC_PARITY_EN
    logic              inject_perr;
    logic              parity_err;

    modport master (
        output _cs, _w, addr, wmask, data_in, inject_perr,
        input  data_out, _ack, addr_err, parity_err
    );

    modport slave (
        input  _cs, _w, addr, wmask, data_in, inject_perr,
        output data_out, _ack, addr_err, parity_err
    );
`else
    modport master (
        output _cs, _w, addr, wmask, data_in,
        input  data_out, _ack, addr_err
    );

    modport slave (
        input  _cs, _w, addr, wmask, data_in,
        output data_out, _ack, addr_err
    );
`endif
endinterface

// File: rtl/main_ram_array.sv
// Word storage with per-lane masked writes and a registered read port.
// With MAIN_RAM_SYNC_PARITY_EN each lane also keeps an even-parity bit.
module main_ram_array
    import main_ram_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             we,
    input  logic             re,
    input  logic             rclr,
    input  logic [AW-1:0]    addr,
    input  logic [LANES-1:0] wmask,
    input  logic [WIDTH-1:0] wdata,
`ifdef MAIN_RAM_SYNC_PARITY_EN
    input  logic             inject_perr,
    output logic             perr,
`endif
    output logic [WIDTH-1:0] rdata
);

    localparam int LW = lane_w(WIDTH, LANES);

    logic [WIDTH-1:0] mem [DEPTH];
`ifdef MAIN_RAM_SYNC_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
`endif

    // Storage has no reset: contents survive a reset and unwritten words read X.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
`ifdef MAIN_RAM_SYNC_PARITY_EN
                    par_mem[addr][i] <= (^wdata[i*LW +: LW]) ^ ((i == 0) && inject_perr);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

`ifdef MAIN_RAM_SYNC_PARITY_EN
    always_comb begin
        perr = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (par_mem[addr][i] != (^mem[addr][i*LW +: LW])) begin
                perr = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/main_ram_sync.sv
// Handshaked main memory model: accepts an access on _cs, waits WAIT_STATES
// cycles, then strobes _ack. Parity checking is added by MAIN_RAM_SYNC_PARITY_EN.
module main_ram_sync
    import main_ram_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int LANES       = 2,
    parameter int ADDR_W      = 20,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic           clk,
    input  logic           _reset,
    main_ram_sync_if.slave bus
);

    localparam int                AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  WS_LOAD = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;

    logic              cap_w;
    logic [ADDR_W-1:0] cap_addr;
    logic [LANES-1:0]  cap_wmask;
    logic [WIDTH-1:0]  cap_data;

    logic              acc_w;
    logic [ADDR_W-1:0] acc_addr;
    logic [LANES-1:0]  acc_wmask;
    logic [WIDTH-1:0]  acc_data;
    logic              in_range;
    logic              enter_ack;
    logic              mem_we;
    logic              mem_re;
    logic              mem_rclr;

    logic              ack_q;
    logic              addr_err_q;
    logic [WIDTH-1:0]  rdata;

`ifdef MAIN_RAM_SYNC_PARITY_EN
    logic              cap_inj;
    logic              acc_inj;
    logic              perr;
    logic              parity_err_q;
`endif

    // With zero wait states the commit happens on the acceptance edge itself,
    // so the array must see the live bus rather than the captured copy.
    always_comb begin
        if (state == IDLE) begin
            acc_w     = bus._w;
            acc_addr  = bus.addr;
            acc_wmask = bus.wmask;
            acc_data  = bus.data_in;
        end else begin
            acc_w     = cap_w;
            acc_addr  = cap_addr;
            acc_wmask = cap_wmask;
            acc_data  = cap_data;
        end
    end

`ifdef MAIN_RAM_SYNC_PARITY_EN
    assign acc_inj = (state == IDLE) ? bus.inject_perr : cap_inj;
`endif

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (!bus._cs) begin
                    state_n = (WAIT_STATES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (bus._cs) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n = ACK;
                end
            end
            ACK: begin
                state_n = bus._cs ? IDLE : RECOVER;
            end
            RECOVER: begin
                if (bus._cs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            cnt <= '0;
        end else if ((state == IDLE) && !bus._cs) begin
            cnt <= WS_LOAD;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && !bus._cs) begin
            cap_w     <= bus._w;
            cap_addr  <= bus.addr;
            cap_wmask <= bus.wmask;
            cap_data  <= bus.data_in;
`ifdef MAIN_RAM_SYNC_PARITY_EN
            cap_inj   <= bus.inject_perr;
`endif
        end
    end

    // Gating with _reset keeps a clock edge during reset from committing a write.
    assign in_range  = {1'b0, acc_addr} < DEPTH_L;
    assign enter_ack = _reset && (state_n == ACK);
    assign mem_we    = enter_ack && !acc_w && in_range && (|acc_wmask);
    assign mem_re    = enter_ack && acc_w && in_range;
    assign mem_rclr  = enter_ack && acc_w && !in_range;

    main_ram_array #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk         (clk),
        ._reset      (_reset),
        .we          (mem_we),
        .re          (mem_re),
        .rclr        (mem_rclr),
        .addr        (acc_addr[AW-1:0]),
        .wmask       (acc_wmask),
        .wdata       (acc_data),
`ifdef MAIN_RAM_SYNC_PARITY_EN
        .inject_perr (acc_inj),
        .perr        (perr),
`endif
        .rdata       (rdata)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            ack_q      <= 1'b1;
            addr_err_q <= 1'b0;
        end else begin
            ack_q      <= !enter_ack;
            addr_err_q <= enter_ack && !in_range;
        end
    end

`ifdef MAIN_RAM_SYNC_PARITY_EN
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= mem_re && perr;
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    assign bus._ack     = ack_q;
    assign bus.addr_err = addr_err_q;
    assign bus.data_out = rdata;

endmodule
